// File: rtl/tt_um_sowmya_quad_decoder_if.sv
// Tiny Tapeout style pin bundle for the quadrature decoder.
interface tt_um_sowmya_quad_decoder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in, uio_in, ena,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ui_in, uio_in, ena,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_sowmya_quad_decoder.sv
// Quadrature decoder: synchronize and debounce A/B, decode x4/x1 steps into an
// 8-bit wrapping position count with direction, step pulse and sticky error.
module tt_um_sowmya_quad_decoder #(
  parameter int FILT_LEN = 3
) (
  input logic clk,
  input logic rst_n,
  tt_um_sowmya_quad_decoder_if.slave bus
);

  localparam logic [4:0] FLEN   = 5'(FILT_LEN);
  localparam logic [4:0] SETTLE = 5'(FILT_LEN + 3);

  typedef struct packed {
    logic moved;
    logic dbl;
    logic up;
    logic dn;
  } dec_t;

  logic [1:0] ab, s1, s2, filt, cand, prev;
  logic [3:0] run;
  logic [4:0] run_nxt;
  logic [4:0] settle;
  logic [7:0] count;
  logic       dir, step, err;
  logic       cnt_en, clr, mode;
  logic       active, do_step;
  dec_t       dec;

  // State encoding is {A,B}; ui_in carries A on bit 0 and B on bit 1.
  assign ab     = {bus.ui_in[0], bus.ui_in[1]};
  assign cnt_en = bus.ui_in[2];
  assign clr    = bus.ui_in[3];
  assign mode   = bus.ui_in[4];

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ui_in[7:5], bus.uio_in, bus.ena};

  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      2'b00:   next_up = 2'b10;
      2'b10:   next_up = 2'b11;
      2'b11:   next_up = 2'b01;
      default: next_up = 2'b00;
    endcase
  endfunction

  // Run length including the current sample; a changed s2 starts a new run.
  assign run_nxt = (run != 4'd0 && s2 == cand) ? {1'b0, run} + 5'd1 : 5'd1;

  always_comb begin
    dec       = '0;
    dec.moved = (prev != filt);
    dec.dbl   = ((prev ^ filt) == 2'b11);
    if (dec.moved && !dec.dbl) begin
      if (mode) begin
        dec.up = (prev == 2'b01) && (filt == 2'b00);
        dec.dn = (prev == 2'b00) && (filt == 2'b01);
      end else begin
        dec.up = (next_up(prev) == filt);
        dec.dn = !dec.up;
      end
    end
  end

  assign active  = (settle == 5'd0);
  assign do_step = active && cnt_en && (dec.up || dec.dn);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 2'b00;
      s2     <= 2'b00;
      filt   <= 2'b00;
      cand   <= 2'b00;
      run    <= 4'd0;
      prev   <= 2'b00;
      settle <= SETTLE;
      count  <= 8'd0;
      dir    <= 1'b0;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      s1   <= ab;
      s2   <= s1;
      prev <= filt;

      if (s2 == filt) begin
        run <= 4'd0;
      end else if (run_nxt == FLEN) begin
        filt <= s2;
        run  <= 4'd0;
      end else begin
        run  <= run_nxt[3:0];
        cand <= s2;
      end

      if (!active) settle <= settle - 5'd1;

      if (clr) begin
        count <= 8'd0;
        err   <= 1'b0;
        step  <= 1'b0;
      end else begin
        step <= do_step;
        if (do_step) begin
          count <= dec.up ? count + 8'd1 : count - 8'd1;
          dir   <= dec.up;
        end
        if (active && dec.dbl) err <= 1'b1;
      end
    end
  end

  assign bus.uo_out  = count;
  assign bus.uio_out = {5'b0, err, step, dir};
  assign bus.uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_sowmya_quad_decoder.sv
// Directed bench for the quadrature decoder with FILT_LEN=3.
module tb_tt_um_sowmya_quad_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   step_total = 0;
  int   last_step_cyc = -1;

  tt_um_sowmya_quad_decoder_if bus();

  tt_um_sowmya_quad_decoder #(.FILT_LEN(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.uio_out[1] === 1'b1) begin
      step_total    <= step_total + 1;
      last_step_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // a = A (ui_in[0]), b = B (ui_in[1])
  task automatic set_ab(input logic a, input logic b);
    bus.ui_in[0] = a;
    bus.ui_in[1] = b;
  endtask

  task automatic do_reset(input logic a, input logic b);
    set_ab(a, b);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    int base;
    set_ab(1'b1, 1'b1);
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (bus.uo_out !== 8'd0 || bus.uio_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: count=%0d uio_out=%b, want 0/00000000", bus.uo_out, bus.uio_out);
    end
    checks++;
    if (bus.uio_oe !== 8'b0000_0111) begin
      errors++;
      $display("FAIL uio_oe: got %b want 00000111", bus.uio_oe);
    end
    base = step_total;
    rst_n = 1'b1;
    tick(10);
    checks++;
    if (bus.uo_out !== 8'd0 || bus.uio_out[2] !== 1'b0 || step_total != base) begin
      errors++;
      $display("FAIL settle_11: count=%0d err=%b steps=%0d, want 0/0/0",
               bus.uo_out, bus.uio_out[2], step_total - base);
    end
  endtask

  task automatic test_x4_up();
    int base, d;
    do_reset(1'b0, 1'b0);
    bus.ui_in[4] = 1'b0;
    bus.ui_in[2] = 1'b1;
    base = step_total;
    set_ab(1'b1, 1'b0);
    d = cyc;
    tick(5);
    checks++;
    if (step_total != base) begin
      errors++;
      $display("FAIL x4_early_step: got %0d pulses before edge N+5, want 0", step_total - base);
    end
    tick(3);
    checks++;
    if (step_total != base + 1 || last_step_cyc != d + 6) begin
      errors++;
      $display("FAIL x4_first_latency: pulses=%0d at cyc %0d, want 1 at cyc %0d",
               step_total - base, last_step_cyc, d + 6);
    end
    set_ab(1'b1, 1'b1); tick(8);
    set_ab(1'b0, 1'b1); tick(8);
    set_ab(1'b0, 1'b0); tick(8);
    checks++;
    if (bus.uo_out !== 8'd4 || bus.uio_out[0] !== 1'b1 || step_total != base + 4) begin
      errors++;
      $display("FAIL x4_up_cycle: count=%0d dir=%b pulses=%0d, want 4/1/4",
               bus.uo_out, bus.uio_out[0], step_total - base);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b0);
    set_ab(1'b0, 1'b1); tick(8);
    checks++;
    if (bus.uo_out !== 8'd255 || bus.uio_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down: count=%0d dir=%b, want 255/0", bus.uo_out, bus.uio_out[0]);
    end
    set_ab(1'b0, 1'b0); tick(8);
    checks++;
    if (bus.uo_out !== 8'd0 || bus.uio_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: count=%0d dir=%b, want 0/1", bus.uo_out, bus.uio_out[0]);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = step_total;
    set_ab(1'b1, 1'b0); tick(2);
    set_ab(1'b0, 1'b0); tick(10);
    checks++;
    if (bus.uo_out !== 8'd0 || step_total != base || bus.uio_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL glitch: count=%0d pulses=%0d err=%b, want 0/0/0",
               bus.uo_out, step_total - base, bus.uio_out[2]);
    end
  endtask

  task automatic test_err_clr();
    int base;
    do_reset(1'b0, 1'b0);
    base = step_total;
    set_ab(1'b1, 1'b1); tick(8);
    checks++;
    if (bus.uio_out[2] !== 1'b1 || bus.uo_out !== 8'd0 || step_total != base) begin
      errors++;
      $display("FAIL double_change: err=%b count=%0d pulses=%0d, want 1/0/0",
               bus.uio_out[2], bus.uo_out, step_total - base);
    end
    set_ab(1'b0, 1'b1); tick(8);
    checks++;
    if (bus.uio_out[2] !== 1'b1 || bus.uo_out !== 8'd1) begin
      errors++;
      $display("FAIL err_sticky: err=%b count=%0d, want 1/1", bus.uio_out[2], bus.uo_out);
    end
    bus.ui_in[3] = 1'b1; tick(1);
    bus.ui_in[3] = 1'b0;
    checks++;
    if (bus.uio_out[2] !== 1'b0 || bus.uo_out !== 8'd0) begin
      errors++;
      $display("FAIL clr: err=%b count=%0d, want 0/0", bus.uio_out[2], bus.uo_out);
    end
    base = step_total;
    set_ab(1'b0, 1'b0); tick(5);
    bus.ui_in[3] = 1'b1; tick(1);
    bus.ui_in[3] = 1'b0; tick(4);
    checks++;
    if (bus.uo_out !== 8'd0 || step_total != base) begin
      errors++;
      $display("FAIL clr_vs_step: count=%0d pulses=%0d, want 0/0", bus.uo_out, step_total - base);
    end
  endtask

  task automatic test_x1_and_midreset();
    int base, d;
    do_reset(1'b0, 1'b0);
    bus.ui_in[4] = 1'b1;
    bus.ui_in[2] = 1'b1;
    base = step_total;
    set_ab(1'b1, 1'b0); tick(8);
    set_ab(1'b1, 1'b1); tick(8);
    set_ab(1'b0, 1'b1); tick(8);
    checks++;
    if (step_total != base || bus.uo_out !== 8'd0) begin
      errors++;
      $display("FAIL x1_no_early: count=%0d pulses=%0d, want 0/0", bus.uo_out, step_total - base);
    end
    set_ab(1'b0, 1'b0);
    d = cyc;
    tick(8);
    checks++;
    if (bus.uo_out !== 8'd1 || step_total != base + 1 || last_step_cyc != d + 6 || bus.uio_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL x1_up: count=%0d pulses=%0d at %0d dir=%b, want 1/1 at %0d/1",
               bus.uo_out, step_total - base, last_step_cyc, bus.uio_out[0], d + 6);
    end
    bus.ui_in[2] = 1'b0;
    base = step_total;
    set_ab(1'b1, 1'b0); tick(8);
    set_ab(1'b1, 1'b1); tick(8);
    set_ab(1'b0, 1'b1); tick(8);
    set_ab(1'b0, 1'b0); tick(8);
    checks++;
    if (bus.uo_out !== 8'd1 || step_total != base || bus.uio_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL x1_disabled: count=%0d pulses=%0d dir=%b, want 1/0/1",
               bus.uo_out, step_total - base, bus.uio_out[0]);
    end
    bus.ui_in[4] = 1'b0;
    bus.ui_in[2] = 1'b1;
    set_ab(1'b1, 1'b0); tick(8);
    checks++;
    if (bus.uo_out !== 8'd2) begin
      errors++;
      $display("FAIL pre_midreset: count=%0d want 2", bus.uo_out);
    end
    set_ab(1'b1, 1'b1); tick(3);
    rst_n = 1'b0; tick(1);
    checks++;
    if (bus.uo_out !== 8'd0 || bus.uio_out !== 8'd0) begin
      errors++;
      $display("FAIL midreset: count=%0d uio_out=%b, want 0/00000000", bus.uo_out, bus.uio_out);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.ui_in  = 8'hE0;
    bus.uio_in = 8'hA5;
    bus.ena    = 1'b1;
    test_reset();
    test_x4_up();
    test_wrap();
    test_glitch();
    test_err_clr();
    test_x1_and_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/tt_um_sowmya_quad_decoder.md
TT_UM_SOWMYA_QUAD_DECODER -- requirements
Module: tt_um_sowmya_quad_decoder

Interface
REQ-001 Parameter: FILT_LEN, default 3, is the number of consecutive identical synchronized samples needed to accept a new A/B level (legal range 1-15).
REQ-002 Port: clk  input  1  is the single clock; every flop in the block SHALL be clocked on its rising edge.
REQ-003 Port: rst_n  input  1  is the reset, synchronous and active-low.
REQ-004 Port: ui_in  input  8  carries [0]=A, [1]=B, [2]=cnt_en, [3]=clr (synchronous, active-high), [4]=mode (0=x4, 1=x1); bits [7:5] SHALL be ignored.
REQ-005 Port: uo_out  output  8  is the 8-bit position count.
REQ-006 Port: uio_in  input  8  SHALL be ignored.
REQ-007 Port: uio_out  output  8  carries [0]=dir (1=up), [1]=step (one-cycle pulse per counted step), [2]=err (sticky); bits [7:3] SHALL be 0.
REQ-008 Port: uio_oe  output  8  SHALL be the constant 8'b0000_0111.
REQ-009 Port: ena  input  1  SHALL be ignored.

Function
REQ-010 A and B SHALL each pass through a 2-flop synchronizer (s1, s2).
REQ-011 Filter: the filtered pair {fA,fB} SHALL update to s2 only after s2 has differed from {fA,fB} with the same value for FILT_LEN consecutive cycles; any change in s2 SHALL restart the run.
REQ-012 Latency: when a new steady level is first sampled at edge N, count, dir and step SHALL reflect it after edge N+2+FILT_LEN (5 cycles when FILT_LEN=3).
REQ-013 Decode compares prev against {fA,fB}, with state={A,B}: up sequence 00->10->11->01->00; down is the reverse.
REQ-014 x4 mode: every legal up transition SHALL increment the count and every legal down transition SHALL decrement it.
REQ-015 x1 mode: only 01->00 SHALL increment and only 00->01 SHALL decrement; other legal transitions SHALL be tracked without counting.
REQ-016 A transition in which both bits change SHALL set err, with no count change and no step pulse; prev SHALL still update.
REQ-017 When a step is counted: step=1 for exactly that cycle, and dir SHALL be set to 1 (up) or 0 (down); otherwise step=0 and dir SHALL hold.
REQ-018 cnt_en=0: transitions SHALL be tracked (prev updates, err can still set), with no count change, no step pulse and dir held.
REQ-019 Arithmetic is modulo 256: 255+1=0 and 0-1=255, with no saturation or flag.
REQ-020 clr=1 SHALL force count=0 and err=0 in the next cycle, taking priority over a simultaneous step (step pulse suppressed) and over a simultaneous error; dir SHALL hold.
REQ-021 err SHALL stay set until clr or reset.

Reset
REQ-022 rst_n=0 at a clock edge SHALL set count=0, dir=0, step=0 and err=0, and SHALL set s1, s2, {fA,fB} and prev to 00 with the filter run counter at 0; this applies regardless of operation in progress.
REQ-023 Settle window: for FILT_LEN+3 cycles after rst_n returns high, prev SHALL follow {fA,fB} with no counting, no step pulse and no err setting.
REQ-024 After the settle window, normal decoding SHALL begin from the settled state.

Verification (FILT_LEN=3)
REQ-025 Hold AB=11 through reset and release, wait 10 cycles -> count=0, err=0, step never pulses.
REQ-026 x4 mode, cnt_en=1, AB 00->10->11->01->00 with each level held 8 cycles -> count=4, dir=1, four 1-cycle step pulses, first at 5 cycles after the first edge.
REQ-027 From count=0, one down step (00->01) -> count=255, dir=0; then one up step (01->00) -> count=0, dir=1.
REQ-028 A pulsed high for 2 cycles from AB=00 -> count unchanged, no step pulse, err=0.
REQ-029 AB 00->11 in one cycle -> err=1 with count unchanged; err stays 1 through later legal steps; clr=1 for 1 cycle -> count=0, err=0; clr asserted in the same cycle as a step -> count=0 and no step pulse.
REQ-030 x1 mode, one full up cycle -> count+1, with the step pulse only on 01->00; repeat with cnt_en=0 -> count unchanged; assert rst_n=0 mid-sequence -> all outputs 0 the following cycle.
